// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - single-address I2C target: START/STOP detect, address match, write receive, read transmit
module i2c_slave_responder #(
  parameter logic [6:0] ADDRESS     = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_request,
  output logic       rw,
  output logic       busy,
  output logic       stop_detected
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDRESS, S_ADDR_ACK, S_WRITE_DATA, S_WRITE_ACK,
    S_READ_DATA, S_READ_ACK, S_WAIT_STOP, S_IGNORE
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_d, sda_d;
  logic                   start_ev, stop_ev, scl_rise, scl_fall;
  logic [2:0]             cnt, cnt_n;
  logic                   phase, phase_n;
  logic [6:0]             sh, sh_n;
  logic [7:0]             rx_data_n;
  logic                   sda_n, rx_valid_n, tx_request_n, rw_n, busy_n, stop_n;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;

  // Synchronisers reset to the idle bus level so reset release never fakes an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync      <= '1;
      sda_sync      <= '1;
      scl_d         <= 1'b1;
      sda_d         <= 1'b1;
      state         <= S_IDLE;
      cnt           <= 3'd0;
      phase         <= 1'b0;
      sh            <= 7'd0;
      sda_drive_low <= 1'b0;
      rx_data       <= 8'd0;
      rx_valid      <= 1'b0;
      tx_request    <= 1'b0;
      rw            <= 1'b0;
      busy          <= 1'b0;
      stop_detected <= 1'b0;
    end else begin
      scl_sync      <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync      <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d         <= scl_s;
      sda_d         <= sda_s;
      state         <= state_n;
      cnt           <= cnt_n;
      phase         <= phase_n;
      sh            <= sh_n;
      sda_drive_low <= sda_n;
      rx_data       <= rx_data_n;
      rx_valid      <= rx_valid_n;
      tx_request    <= tx_request_n;
      rw            <= rw_n;
      busy          <= busy_n;
      stop_detected <= stop_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    phase_n      = phase;
    sh_n         = sh;
    sda_n        = sda_drive_low;
    rx_data_n    = rx_data;
    rx_valid_n   = 1'b0;
    tx_request_n = 1'b0;
    rw_n         = rw;
    busy_n       = busy;
    stop_n       = 1'b0;
    if (start_ev) begin
      state_n = S_ADDRESS;
      cnt_n   = 3'd0;
      phase_n = 1'b0;
      sda_n   = 1'b0;
    end else if (stop_ev) begin
      state_n = S_IDLE;
      cnt_n   = 3'd0;
      phase_n = 1'b0;
      sda_n   = 1'b0;
      busy_n  = 1'b0;
      stop_n  = 1'b1;
    end else begin
      case (state)
        S_ADDRESS: if (scl_rise) begin
          sh_n  = {sh[5:0], sda_s};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            phase_n = 1'b0;
            if (sh == ADDRESS) begin
              rw_n    = sda_s;
              busy_n  = 1'b1;
              state_n = S_ADDR_ACK;
            end else begin
              busy_n  = 1'b0;
              state_n = S_IGNORE;
            end
          end
        end
        // phase=0: waiting for the fall that opens the ACK bit; phase=1: ACK bit on the bus.
        S_ADDR_ACK: begin
          if (scl_fall && !phase) begin
            sda_n   = 1'b1;
            phase_n = 1'b1;
          end else if (scl_fall) begin
            phase_n = 1'b0;
            cnt_n   = 3'd0;
            if (rw) begin
              sh_n    = tx_data[6:0];
              sda_n   = ~tx_data[7];
              state_n = S_READ_DATA;
            end else begin
              sda_n   = 1'b0;
              state_n = S_WRITE_DATA;
            end
          end else if (scl_rise && phase && rw) begin
            tx_request_n = 1'b1;
          end
        end
        S_WRITE_DATA: if (scl_rise) begin
          sh_n  = {sh[5:0], sda_s};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_data_n  = {sh, sda_s};
            rx_valid_n = 1'b1;
            phase_n    = 1'b0;
            state_n    = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_n   = 1'b1;
            phase_n = 1'b1;
          end else begin
            sda_n   = 1'b0;
            phase_n = 1'b0;
            cnt_n   = 3'd0;
            state_n = S_WRITE_DATA;
          end
        end
        // MSB went out on entry, so sh only holds the seven bits still to send.
        S_READ_DATA: if (scl_fall) begin
          if (cnt == 3'd7) begin
            sda_n   = 1'b0;
            cnt_n   = 3'd0;
            phase_n = 1'b0;
            state_n = S_READ_ACK;
          end else begin
            sda_n = ~sh[6];
            sh_n  = {sh[5:0], 1'b0};
            cnt_n = cnt + 3'd1;
          end
        end
        S_READ_ACK: begin
          if (scl_rise && !phase) begin
            if (!sda_s) begin
              tx_request_n = 1'b1;
              phase_n      = 1'b1;
            end else begin
              state_n = S_WAIT_STOP;
            end
          end else if (scl_fall && phase) begin
            sh_n    = tx_data[6:0];
            sda_n   = ~tx_data[7];
            cnt_n   = 3'd0;
            phase_n = 1'b0;
            state_n = S_READ_DATA;
          end
        end
        S_IDLE, S_WAIT_STOP, S_IGNORE: sda_n = 1'b0;
        default: begin
          sda_n   = 1'b0;
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule
